execute_pipe: RTL and testbench

//  Registered, parametrised execute stage: resolves operand forwarding (WB/MEM), selects reg/imm

---
 rtl/execute_pipe.sv | 119 +++++++++++
 tb/tb_execute_pipe.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/execute_pipe.sv
// execute_pipe: registered execute stage with operand forwarding, 1-cycle ALU, iterative MUL and EX/MEM output register
// Ports: clk/reset (async, active-high); valid_in/ready_out upstream handshake;
// data1/data2/data3 rs1/rs2/imm; forwardM/forwardWB bypass values with 2-bit selectors;
// data2Selector picks imm as operand B; aluControl opcode; stall_in downstream hold;
// valid_out/aluOutput/data2AfterForward/N/Z/V/C registered results.
module execute_pipe #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  input  logic [WIDTH-1:0] forwardM,
  input  logic [WIDTH-1:0] forwardWB,
  input  logic [1:0]       data1ForwardSelector,
  input  logic [1:0]       data2ForwardSelector,
  input  logic             data2Selector,
  input  logic [2:0]       aluControl,
  input  logic             stall_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] aluOutput,
  output logic [WIDTH-1:0] data2AfterForward,
  output logic             N,
  output logic             Z,
  output logic             V,
  output logic             C
);
  localparam int SW = $clog2(WIDTH);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a, d2, b, r, mplier, mul_d2;
  logic [2*WIDTH-1:0] acc, mcand, prod;
  logic [SW-1:0] cnt, amt;
  logic c_f, v_f, out_free, accept, is_mul, mul_last;
  assign a = data1ForwardSelector == 2'b01 ? forwardWB :
             data1ForwardSelector == 2'b10 ? forwardM : data1;
  assign d2 = data2ForwardSelector == 2'b01 ? forwardWB :
              data2ForwardSelector == 2'b10 ? forwardM : data2;
  assign b = data2Selector ? data3 : d2;
  assign amt = b[SW-1:0];
  assign out_free = !(valid_out && stall_in);
  assign ready_out = (state == IDLE) && out_free;
  assign accept = valid_in && ready_out;
  assign is_mul = MUL_EN && (aluControl == 3'b111);
  assign mul_last = (state == MUL) && (cnt == '0);
  // final partial product folded in combinationally so the last iteration loads the output directly
  assign prod = acc + (mplier[0] ? mcand : '0);
  assign state_nx = (accept && is_mul) ? MUL : (mul_last && out_free) ? IDLE : state;
  always_comb begin
    r = '0;
    c_f = 1'b0;
    v_f = 1'b0;
    case (aluControl)
      3'b000: begin
        {c_f, r} = {1'b0, a} + {1'b0, b};
        v_f = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        r = a - b;
        c_f = a >= b;
        v_f = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      // the extra bit catches the last bit shifted out (0 for amount 0)
      3'b101: {c_f, r} = {1'b0, a} << amt;
      3'b110: {r, c_f} = {a, 1'b0} >> amt;
      default: r = '0;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      valid_out <= 1'b0;
      aluOutput <= '0;
      data2AfterForward <= '0;
      {N, Z, V, C} <= 4'b0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      mul_d2 <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (accept && is_mul) begin
        acc <= '0;
        mcand <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        mul_d2 <= d2;
        cnt <= SW'(WIDTH - 1);
      end else if (state == MUL && !mul_last) begin
        acc <= prod;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt - 1'b1;
      end
      if (out_free) begin
        if (accept && !is_mul) begin
          valid_out <= 1'b1;
          aluOutput <= r;
          data2AfterForward <= d2;
          {N, Z, V, C} <= {r[WIDTH-1], r == '0, v_f, c_f};
        end else if (mul_last) begin
          valid_out <= 1'b1;
          aluOutput <= prod[WIDTH-1:0];
          data2AfterForward <= mul_d2;
          {N, Z, V, C} <= {prod[WIDTH-1], prod[WIDTH-1:0] == '0, 1'b0, |prod[2*WIDTH-1:WIDTH]};
        end else begin
          valid_out <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_execute_pipe.sv
// tb_execute_pipe: directed vector table plus MUL, stall and reset sequences for execute_pipe
module tb_execute_pipe;
  logic clk = 1'b0, reset, valid_in, ready_out, data2Selector, stall_in;
  logic valid_out, N, Z, V, C;
  logic [7:0] data1, data2, data3, forwardM, forwardWB, aluOutput, data2AfterForward;
  logic [1:0] data1ForwardSelector, data2ForwardSelector;
  logic [2:0] aluControl;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  execute_pipe #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .data1(data1), .data2(data2), .data3(data3), .forwardM(forwardM), .forwardWB(forwardWB),
    .data1ForwardSelector(data1ForwardSelector), .data2ForwardSelector(data2ForwardSelector),
    .data2Selector(data2Selector), .aluControl(aluControl), .stall_in(stall_in),
    .valid_out(valid_out), .aluOutput(aluOutput), .data2AfterForward(data2AfterForward),
    .N(N), .Z(Z), .V(V), .C(C)
  );
  typedef struct {
    logic [2:0] op;
    logic [7:0] d1, d2, d3, fm, fwb;
    logic [1:0] s1, s2;
    logic dsel;
    logic [7:0] res, d2o;
    logic [3:0] nzvc;
  } vec_t;
  vec_t v[15];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic set_in(input vec_t x);
    aluControl = x.op;
    data1 = x.d1;
    data2 = x.d2;
    data3 = x.d3;
    forwardM = x.fm;
    forwardWB = x.fwb;
    data1ForwardSelector = x.s1;
    data2ForwardSelector = x.s2;
    data2Selector = x.dsel;
  endtask
  task automatic simple(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    vec_t t;
    t = '{op, x, y, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00, 4'h0};
    set_in(t);
  endtask
  task automatic run_mul(input logic [7:0] x, input logic [7:0] y, input logic [7:0] res, input logic [3:0] f);
    int n;
    @(negedge clk);
    simple(3'b111, x, y);
    valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    chk("mul_ready_low", ready_out, 0);
    chk("mul_valid_low", valid_out, 0);
    n = 0;
    while (!ready_out && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("mul_latency", n, 8);
    chk("mul_res", aluOutput, res);
    chk("mul_flags", {N, Z, V, C}, f);
    chk("mul_d2", data2AfterForward, y);
    chk("mul_valid", valid_out, 1);
    @(posedge clk);
    #1 chk("mul_valid_drop", valid_out, 0);
    chk("mul_res_hold", aluOutput, res);
  endtask
  initial begin
    v[0]  = '{3'b000, 8'h7F, 8'h01, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 8'h80, 8'h01, 4'b1010};
    v[1]  = '{3'b001, 8'h05, 8'h99, 8'h05, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1, 8'h00, 8'h99, 4'b0101};
    v[2]  = '{3'b001, 8'h03, 8'h05, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 8'hFE, 8'h05, 4'b1000};
    v[3]  = '{3'b000, 8'hAA, 8'h55, 8'h00, 8'h10, 8'h03, 2'b10, 2'b01, 1'b0, 8'h13, 8'h03, 4'b0000};
    v[4]  = '{3'b010, 8'hF0, 8'h3C, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 8'h30, 8'h3C, 4'b0000};
    v[5]  = '{3'b011, 8'h0F, 8'hF0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 8'hFF, 8'hF0, 4'b1000};
    v[6]  = '{3'b100, 8'hAA, 8'hAA, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 8'h00, 8'hAA, 4'b0100};
    v[7]  = '{3'b101, 8'h81, 8'h01, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 8'h02, 8'h01, 4'b0001};
    v[8]  = '{3'b110, 8'h81, 8'h01, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 8'h40, 8'h01, 4'b0001};
    v[9]  = '{3'b101, 8'h81, 8'h08, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 8'h81, 8'h08, 4'b1000};
    v[10] = '{3'b110, 8'h80, 8'h07, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 8'h01, 8'h07, 4'b0000};
    v[11] = '{3'b000, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 8'h00, 8'h01, 4'b0101};
    v[12] = '{3'b001, 8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 8'h7F, 8'h01, 4'b0011};
    v[13] = '{3'b000, 8'h05, 8'h44, 8'h02, 8'h70, 8'h00, 2'b11, 2'b10, 1'b1, 8'h07, 8'h70, 4'b0000};
    v[14] = '{3'b001, 8'h7F, 8'hFF, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 8'h80, 8'hFF, 4'b1010};
    reset = 1'b1;
    valid_in = 1'b0;
    stall_in = 1'b0;
    simple(3'b000, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1 chk("rst_valid", valid_out, 0);
    chk("rst_res", aluOutput, 0);
    chk("rst_d2", data2AfterForward, 0);
    chk("rst_flags", {N, Z, V, C}, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_ready", ready_out, 1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      set_in(v[i]);
      valid_in = 1'b1;
      chk($sformatf("v%0d_ready", i), ready_out, 1);
      @(posedge clk);
      #1 valid_in = 1'b0;
      chk($sformatf("v%0d_res", i), aluOutput, v[i].res);
      chk($sformatf("v%0d_d2", i), data2AfterForward, v[i].d2o);
      chk($sformatf("v%0d_flags", i), {N, Z, V, C}, v[i].nzvc);
      chk($sformatf("v%0d_valid", i), valid_out, 1);
    end
    run_mul(8'h10, 8'h11, 8'h10, 4'b0001);
    run_mul(8'hFF, 8'hFF, 8'h01, 4'b0001);
    run_mul(8'h03, 8'h05, 8'h0F, 4'b0000);
    @(negedge clk);
    simple(3'b000, 8'h01, 8'h02);
    valid_in = 1'b1;
    @(posedge clk);
    #1 chk("stall_first", aluOutput, 8'h03);
    simple(3'b000, 8'h04, 8'h04);
    stall_in = 1'b1;
    #1 chk("stall_ready", ready_out, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk($sformatf("stall%0d_res", i), aluOutput, 8'h03);
      chk($sformatf("stall%0d_valid", i), valid_out, 1);
      chk($sformatf("stall%0d_ready", i), ready_out, 0);
    end
    @(negedge clk);
    stall_in = 1'b0;
    #1 chk("unstall_ready", ready_out, 1);
    @(posedge clk);
    #1 valid_in = 1'b0;
    chk("unstall_res", aluOutput, 8'h08);
    chk("unstall_valid", valid_out, 1);
    @(negedge clk);
    simple(3'b111, 8'h03, 8'h05);
    valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("midrst_valid", valid_out, 0);
    chk("midrst_res", aluOutput, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("midrst_ready", ready_out, 1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 chk($sformatf("midrst_stale%0d", i), valid_out, 0);
    end
    chk("midrst_res_after", aluOutput, 0);
    @(negedge clk);
    simple(3'b000, 8'h02, 8'h03);
    valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    chk("post_rst_res", aluOutput, 8'h05);
    chk("post_rst_valid", valid_out, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
